// File: rtl/vga_fb_fill.sv
// Rectangle fill engine: writes one RGB888 colour into a linear framebuffer over a
// clipped rectangle, one pixel per un-stalled cycle, in raster order.
module vga_fb_fill #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x0,
  input  logic [9:0]  cmd_y0,
  input  logic [9:0]  cmd_w,
  input  logic [9:0]  cmd_h,
  input  logic [23:0] cmd_color,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [23:0] fb_wdata,
  input  logic        fb_stall,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // state | meaning
  // IDLE  | waiting for a command (cmd_ready high once out of reset)
  // SETUP | base address computed from the captured origin
  // FILL  | one write request per cycle, advancing on each un-stalled write
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  localparam logic [10:0] H11 = 11'(H_RES);
  localparam logic [10:0] V11 = 11'(V_RES);
  localparam logic [18:0] H19 = 19'(H_RES);

  state_t      r_state, w_next;
  logic        r_armed;
  logic        r_err;
  logic [9:0]  r_x0, r_y0;
  logic [23:0] r_color;
  logic [10:0] r_w_eff, r_h_eff;
  logic [10:0] r_col_cnt, r_row_cnt;
  logic [18:0] r_addr, r_row_addr;

  logic        w_accept, w_bad, w_wr, w_col_tc, w_row_tc;
  logic [10:0] w_x_room, w_y_room, w_w_clip, w_h_clip;
  logic [18:0] w_base;

  assign cmd_ready = (r_state == IDLE) && r_armed;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_bad     = ({1'b0, cmd_x0} >= H11) || ({1'b0, cmd_y0} >= V11) ||
                     (cmd_w == 10'd0) || (cmd_h == 10'd0);

  // Room to the right/bottom edge; only meaningful when the origin is on-screen.
  assign w_x_room  = H11 - {1'b0, cmd_x0};
  assign w_y_room  = V11 - {1'b0, cmd_y0};
  assign w_w_clip  = ({1'b0, cmd_w} < w_x_room) ? {1'b0, cmd_w} : w_x_room;
  assign w_h_clip  = ({1'b0, cmd_h} < w_y_room) ? {1'b0, cmd_h} : w_y_room;

  // y*640 as y*512 + y*128
  assign w_base    = ({9'd0, r_y0} << 9) + ({9'd0, r_y0} << 7) + {9'd0, r_x0};

  assign w_wr      = (r_state == FILL) && !fb_stall;
  assign w_col_tc  = (r_col_cnt == 11'd0);
  assign w_row_tc  = (r_row_cnt == 11'd0);

  assign fb_we     = (r_state == FILL);
  assign fb_addr   = r_addr;
  assign fb_wdata  = r_color;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign err       = r_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_bad) w_next = SETUP;
      SETUP:   w_next = FILL;
      FILL:    if (w_wr && w_col_tc && w_row_tc) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_armed    <= 1'b0;
      r_err      <= 1'b0;
      r_x0       <= '0;
      r_y0       <= '0;
      r_color    <= '0;
      r_w_eff    <= '0;
      r_h_eff    <= '0;
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
      r_addr     <= '0;
      r_row_addr <= '0;
    end else begin
      r_state <= w_next;
      r_armed <= 1'b1;
      r_err   <= w_accept && w_bad;
      if (w_accept && !w_bad) begin
        r_x0    <= cmd_x0;
        r_y0    <= cmd_y0;
        r_color <= cmd_color;
        r_w_eff <= w_w_clip;
        r_h_eff <= w_h_clip;
      end
      if (r_state == SETUP) begin
        r_addr     <= w_base;
        r_row_addr <= w_base;
        r_col_cnt  <= r_w_eff - 11'd1;
        r_row_cnt  <= r_h_eff - 11'd1;
      end
      // Remaining-pixel counters run down; terminal count closes the row / rectangle.
      if (w_wr) begin
        if (!w_col_tc) begin
          r_addr    <= r_addr + 19'd1;
          r_col_cnt <= r_col_cnt - 11'd1;
        end else if (!w_row_tc) begin
          r_row_addr <= r_row_addr + H19;
          r_addr     <= r_row_addr + H19;
          r_col_cnt  <= r_w_eff - 11'd1;
          r_row_cnt  <= r_row_cnt - 11'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_fill.sv
// Self-checking bench for vga_fb_fill: scoreboard of expected writes, per-scenario tasks.
// Cycle numbering: the cycle in which cmd_valid && cmd_ready is sampled is cycle 1.
module tb_vga_fb_fill;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x0, cmd_y0, cmd_w, cmd_h;
  logic [23:0] cmd_color;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [23:0] fb_wdata;
  logic        fb_stall;
  logic        busy, done, err;

  typedef struct packed {
    logic [18:0] a;
    logic [23:0] d;
  } wr_t;

  wr_t         q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_count = 0;
  bit          hold_pend = 0;
  logic [18:0] held_a;
  logic [23:0] held_d;

  vga_fb_fill #(.H_RES(640), .V_RES(480)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .fb_stall(fb_stall), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Write monitor: pops the scoreboard on every completed write and checks stall hold.
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      hold_pend = 0;
    end else begin
      if (fb_we && hold_pend) begin
        n_checks++;
        if (fb_addr !== held_a || fb_wdata !== held_d) begin
          n_fail++;
          $display("FAIL stall_hold addr=%0d data=%h, required addr=%0d data=%h",
                   fb_addr, fb_wdata, held_a, held_d);
        end
      end
      if (fb_we && !fb_stall) begin
        n_checks++;
        wr_count++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write addr=%0d data=%h, required no write", fb_addr, fb_wdata);
        end else begin
          e = q.pop_front();
          if (fb_addr !== e.a || fb_wdata !== e.d) begin
            n_fail++;
            $display("FAIL write addr=%0d data=%h, required addr=%0d data=%h",
                     fb_addr, fb_wdata, e.a, e.d);
          end
        end
      end
      hold_pend = fb_we && fb_stall;
      held_a = fb_addr;
      held_d = fb_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push_wr(input int addr, input logic [23:0] c);
    wr_t e;
    e.a = 19'(addr);
    e.d = c;
    q.push_back(e);
  endfunction

  function automatic void push_rect(input int x0, input int y0, input int w, input int h,
                                    input logic [23:0] c);
    int we, he;
    we = (w < 640 - x0) ? w : 640 - x0;
    he = (h < 480 - y0) ? h : 480 - y0;
    for (int r = 0; r < he; r++)
      for (int cc = 0; cc < we; cc++)
        push_wr((y0 + r) * 640 + x0 + cc, c);
  endfunction

  task automatic drive_cmd(input int x0, input int y0, input int w, input int h,
                           input logic [23:0] c);
    cmd_valid = 1'b1;
    cmd_x0 = 10'(x0);
    cmd_y0 = 10'(y0);
    cmd_w = 10'(w);
    cmd_h = 10'(h);
    cmd_color = c;
  endtask

  // Returns at the negedge of the acceptance cycle; ok=0 on timeout.
  task automatic wait_accept(output bit ok);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ok = cmd_ready;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                         input logic [23:0] c, input bit alt_stall,
                         output int done_cyc, output int ready_cyc, output int writes);
    int cyc, start_wr;
    bit ok;
    done_cyc = 0;
    ready_cyc = 0;
    start_wr = wr_count;
    @(posedge clk); #1;
    drive_cmd(x0, y0, w, h, c);
    wait_accept(ok);
    if (ok) begin
      cyc = 1;
      while (ready_cyc == 0 && cyc < 5000) begin
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        fb_stall = alt_stall && fb_we && !fb_stall;
        @(negedge clk);
        cyc++;
        if (done && done_cyc == 0) done_cyc = cyc;
        if (cmd_ready) ready_cyc = cyc;
      end
      if (ready_cyc == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL completion_timeout cycles=%0d, required cmd_ready to return", cyc);
      end
    end
    cmd_valid = 1'b0;
    fb_stall = 1'b0;
    writes = wr_count - start_wr;
  endtask

  task automatic check_run(input string name, input int done_cyc, input int ready_cyc,
                           input int writes, input int exp_done, input int exp_writes);
    n_checks++;
    if (done_cyc !== exp_done) begin
      n_fail++;
      $display("FAIL %s_done_cycle got=%0d, required %0d", name, done_cyc, exp_done);
    end
    n_checks++;
    if (ready_cyc !== exp_done + 1) begin
      n_fail++;
      $display("FAIL %s_ready_cycle got=%0d, required %0d", name, ready_cyc, exp_done + 1);
    end
    n_checks++;
    if (writes !== exp_writes) begin
      n_fail++;
      $display("FAIL %s_write_count got=%0d, required %0d", name, writes, exp_writes);
    end
    n_checks++;
    if (q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_missing_writes left=%0d, required 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready, fb_we, busy, done, err} !== 5'b0 || fb_addr !== 19'd0 || fb_wdata !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_outputs rdy=%b we=%b busy=%b done=%b err=%b addr=%0d data=%h, required all 0",
               cmd_ready, fb_we, busy, done, err, fb_addr, fb_wdata);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge got=%b, required 0", cmd_ready);
    end
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release got=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    int dc, rc, nw;
    push_wr(1290, 24'hFF0000); push_wr(1291, 24'hFF0000); push_wr(1292, 24'hFF0000);
    push_wr(1930, 24'hFF0000); push_wr(1931, 24'hFF0000); push_wr(1932, 24'hFF0000);
    run_cmd(10, 2, 3, 2, 24'hFF0000, 1'b0, dc, rc, nw);
    check_run("basic", dc, rc, nw, 9, 6);
  endtask

  task automatic test_clip();
    int dc, rc, nw;
    push_wr(307198, 24'h12AB34);
    push_wr(307199, 24'h12AB34);
    run_cmd(638, 479, 5, 5, 24'h12AB34, 1'b0, dc, rc, nw);
    check_run("clip", dc, rc, nw, 5, 2);
    push_rect(0, 100, 7, 3, 24'h00FF00);
    run_cmd(0, 100, 7, 3, 24'h00FF00, 1'b0, dc, rc, nw);
    check_run("rect7x3", dc, rc, nw, 24, 21);
  endtask

  task automatic test_reject();
    int cases[4][4] = '{'{640, 0, 1, 1}, '{5, 5, 0, 1}, '{5, 480, 1, 1}, '{5, 5, 1, 0}};
    bit ok;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      drive_cmd(cases[k][0], cases[k][1], cases[k][2], cases[k][3], 24'h0000FF);
      wait_accept(ok);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int cyc = 2; cyc <= 4; cyc++) begin
        @(negedge clk);
        n_checks++;
        if (err !== (cyc == 2) || busy !== 1'b0 || fb_we !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL reject%0d_cycle%0d err=%b busy=%b we=%b done=%b, required err=%b busy=0 we=0 done=0",
                   k, cyc, err, busy, fb_we, done, (cyc == 2));
        end
      end
    end
  endtask

  task automatic test_stall();
    int dc, rc, nw;
    push_rect(100, 7, 4, 1, 24'hA5C3E1);
    run_cmd(100, 7, 4, 1, 24'hA5C3E1, 1'b1, dc, rc, nw);
    check_run("stall", dc, rc, nw, 11, 4);
  endtask

  task automatic test_reset_mid();
    int dc, rc, nw, start_wr, guard;
    bit ok;
    push_rect(0, 0, 10, 10, 24'h777777);
    start_wr = wr_count;
    @(posedge clk); #1;
    drive_cmd(0, 0, 10, 10, 24'h777777);
    wait_accept(ok);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    guard = 0;
    while (wr_count < start_wr + 3 && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (fb_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 || done !== 1'b0 || fb_addr !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid we=%b busy=%b rdy=%b done=%b addr=%0d, required all 0",
               fb_we, busy, cmd_ready, done, fb_addr);
    end
    n_checks++;
    if (wr_count - start_wr !== 3) begin
      n_fail++;
      $display("FAIL reset_mid_writes got=%0d, required 3", wr_count - start_wr);
    end
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_recover rdy=%b busy=%b, required rdy=1 busy=0", cmd_ready, busy);
    end
    push_rect(5, 5, 1, 1, 24'h0F0F0F);
    run_cmd(5, 5, 1, 1, 24'h0F0F0F, 1'b0, dc, rc, nw);
    check_run("after_reset", dc, rc, nw, 4, 1);
  endtask

  task automatic test_back_to_back();
    int cyc, guard;
    bit ok, seen_done;
    push_rect(20, 3, 3, 2, 24'h112233);
    push_rect(50, 4, 2, 2, 24'h445566);
    @(posedge clk); #1;
    drive_cmd(20, 3, 3, 2, 24'h112233);
    wait_accept(ok);
    @(posedge clk); #1;
    drive_cmd(50, 4, 2, 2, 24'h445566);
    cyc = 1;
    seen_done = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) seen_done = 1;
      if (cmd_ready) break;
    end
    n_checks++;
    if (!seen_done || cyc !== 10) begin
      n_fail++;
      $display("FAIL b2b_second_accept cycle=%0d done_seen=%b, required cycle=10 done_seen=1", cyc, seen_done);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_done got=%b, required 1", done);
    end
    @(negedge clk);
    n_checks++;
    if (q.size() !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain left=%0d busy=%b, required 0 and 0", q.size(), busy);
    end
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_x0 = '0;
    cmd_y0 = '0;
    cmd_w = '0;
    cmd_h = '0;
    cmd_color = '0;
    fb_stall = 1'b0;
    test_reset();
    test_basic();
    test_clip();
    test_reject();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_fill.md
VGA_FB_FILL -- requirements
Module: vga_fb_fill

Interface
- REQ-001 SHALL have parameter H_RES, default 640, meaning framebuffer width in pixels.
- REQ-002 SHALL have parameter V_RES, default 480, meaning framebuffer height in pixels.
- REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
- REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; 0 = reset.
- REQ-005 SHALL have port cmd_valid  input  1  fill command present.
- REQ-006 SHALL have port cmd_ready  output  1  block accepts a command this cycle.
- REQ-007 SHALL have port cmd_x0  input  10  left column of rectangle.
- REQ-008 SHALL have port cmd_y0  input  10  top row of rectangle.
- REQ-009 SHALL have port cmd_w  input  10  rectangle width in pixels.
- REQ-010 SHALL have port cmd_h  input  10  rectangle height in pixels.
- REQ-011 SHALL have port cmd_color  input  24  RGB888 fill colour, {R,G,B}.
- REQ-012 SHALL have port fb_we  output  1  framebuffer write strobe.
- REQ-013 SHALL have port fb_addr  output  19  linear pixel address, y*640+x.
- REQ-014 SHALL have port fb_wdata  output  24  pixel data written.
- REQ-015 SHALL have port fb_stall  input  1  framebuffer cannot take a write this cycle.
- REQ-016 SHALL have port busy  output  1  command in progress.
- REQ-017 SHALL have port done  output  1  one-cycle pulse on command completion.
- REQ-018 SHALL have port err  output  1  one-cycle pulse on rejected command.

Function
- REQ-019 SHALL implement FSM states IDLE, SETUP, FILL, DONE.
- REQ-020 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid && cmd_ready, and all cmd_* fields are captured on that edge.
- REQ-021 SHALL reject a command when x0>=H_RES, y0>=V_RES, w==0, or h==0: err pulses the cycle after acceptance, no write is issued, and the FSM returns to IDLE.
- REQ-022 SHALL otherwise move IDLE->SETUP and clip the rectangle: w_eff = min(w, H_RES-x0) and h_eff = min(h, V_RES-y0).
- REQ-023 SHALL compute the base address in SETUP as (y0<<9)+(y0<<7)+x0, using shifts and adds only with no multiplier; the result must fit in 19 bits.
- REQ-024 SHALL move SETUP->FILL after exactly one cycle.
- REQ-025 SHALL hold fb_we=1 for every FILL cycle; a write completes on fb_we && !fb_stall.
- REQ-026 SHALL hold fb_addr and fb_wdata stable while fb_stall=1.
- REQ-027 SHALL traverse pixels in raster order: column first, then row; at row end it advances the row base by H_RES and resets the column.
- REQ-028 SHALL move FILL->DONE on the completed write of pixel (w_eff-1, h_eff-1).
- REQ-029 SHALL pulse done for exactly one cycle in DONE, then move to IDLE.
- REQ-030 SHALL, with no stall, take 1+1+w_eff*h_eff+1 cycles from the acceptance edge until cmd_ready rises again.
- REQ-031 SHALL drive busy=1 in SETUP, FILL and DONE, and busy=0 in IDLE and during an err return.
- REQ-032 SHALL ignore cmd_valid while busy; it has no effect and no command is queued.
- REQ-033 SHALL drive fb_we=0 outside FILL; fb_addr and fb_wdata are don't-care in those states.
- REQ-034 SHALL write exactly w_eff*h_eff pixels per accepted command, with no duplicates and no omissions, under any fb_stall pattern.

Reset
- REQ-035 SHALL, on reset=0, immediately and asynchronously return the FSM to IDLE, even mid-FILL, and drop any partial command.
- REQ-036 SHALL drive outputs while reset=0 as: cmd_ready=0, fb_we=0, fb_addr=0, fb_wdata=0, busy=0, done=0, err=0.
- REQ-037 SHALL raise cmd_ready on the first rising clk edge after reset deasserts.

Verification
- REQ-038 SHALL cover: cmd (x0=10, y0=2, w=3, h=2, color=FF0000), no stall -> 6 writes at addresses 1290, 1291, 1292, 1930, 1931, 1932, all FF0000; done 9 cycles after acceptance.
- REQ-039 SHALL cover: cmd (x0=638, y0=479, w=5, h=5) -> clipped to 2x1; writes at 307198 and 307199; done pulses.
- REQ-040 SHALL cover: cmd (x0=640, y0=0, w=1, h=1), then separately w=0 -> err pulse each time, fb_we never high, busy stays 0.
- REQ-041 SHALL cover: 4x1 fill with fb_stall high on alternate FILL cycles -> exactly 4 distinct writes, addr/data held during each stall, done after the 4th completed write.
- REQ-042 SHALL cover: reset=0 asserted after the 3rd write of a 10x10 fill -> fb_we=0 and busy=0 at once; after release cmd_ready=1 and a new 1x1 command completes normally.
- REQ-043 SHALL cover: cmd_valid held high during a fill -> second command accepted only when cmd_ready rises after done, not before.
